// File: rtl/data_mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port DataMem.
//   req0/we0/addr0/wdata0 -> ack0 : requester 0 (core load/store path)
//   req1/we1/addr1/wdata1 -> ack1 : requester 1 (test/DMA loader)
//   rdata, grant_id, busy         : shared status back to requesters
//   mem_write_en/mem_address/mem_data_in -> DataMem, mem_data_out <- DataMem
// Handshake: a requester raises reqN with its command and holds it until it
// sees ackN high for one cycle; on the edge after seeing ackN it either drops
// reqN or presents its next command. The command is sampled only at grant.
interface data_mem_arbiter_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         req0;
  logic         we0;
  logic [A-1:0] addr0;
  logic [W-1:0] wdata0;
  logic         ack0;
  logic         req1;
  logic         we1;
  logic [A-1:0] addr1;
  logic [W-1:0] wdata1;
  logic         ack1;
  logic [W-1:0] rdata;
  logic         grant_id;
  logic         busy;
  logic         mem_write_en;
  logic [A-1:0] mem_address;
  logic [W-1:0] mem_data_in;
  logic [W-1:0] mem_data_out;

  // Requester/memory side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_data_out,
    input  ack0, ack1, rdata, grant_id, busy, mem_write_en, mem_address, mem_data_in
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_data_out,
    output ack0, ack1, rdata, grant_id, busy, mem_write_en, mem_address, mem_data_in
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DataMem.
// Each access: IDLE (arbitrate + latch command) -> SERVE (memory access)
// -> ACK (one-cycle ack to the owner) -> IDLE. Three cycles per access.
// Ports:
//   clk_i   : clock, all state on posedge
//   rst_i   : asynchronous active-high reset
//   bus     : data_mem_arbiter_if.slave (requesters + DataMem)
//   state_o : current FSM state (0=IDLE, 1=SERVE, 2=ACK) for observation
module data_mem_arbiter #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  data_mem_arbiter_if.slave     bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         we_q, we_d;
  logic [A-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         grant_q, grant_d;
  logic         last_q, last_d;
  logic         pick1;

  // State register. last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grant_d = grant_q;
    last_d  = last_q;
    // Requester 1 wins if it is alone, or on a tie when 0 had the last grant.
    pick1   = bus.req1 & (~bus.req0 | ~last_q);
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          we_d    = pick1 ? bus.we1    : bus.we0;
          addr_d  = pick1 ? bus.addr1  : bus.addr0;
          wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          grant_d = pick1;
          last_d  = pick1;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // DataMem reads combinationally; capture on the same edge the write
        // would commit.
        if (!we_q) rdata_d = bus.mem_data_out;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. mem_write_en is decoded from state so an async reset during
  // SERVE removes it before the edge and no write commits.
  always_comb begin
    bus.ack0         = (state_q == ST_ACK) && !grant_q;
    bus.ack1         = (state_q == ST_ACK) &&  grant_q;
    bus.mem_write_en = (state_q == ST_SERVE) && we_q;
    bus.mem_address  = addr_q;
    bus.mem_data_in  = wdata_q;
    bus.rdata        = rdata_q;
    bus.grant_id     = grant_q;
    bus.busy         = (state_q != ST_IDLE);
    state_o          = state_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int W = 8;
  localparam int A = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.W(W), .A(A)) bus ();

  data_mem_arbiter #(.W(W), .A(A)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // DataMem stand-in: combinational read, posedge write.
  logic [W-1:0] core [2**A];
  assign bus.mem_data_out = core[bus.mem_address];
  always @(posedge clk) if (bus.mem_write_en) core[bus.mem_address] <= bus.mem_data_in;

  // ---------------- reference model ----------------
  logic [W-1:0] ref_mem [2**A];
  logic [W-1:0] exp_q [$];
  bit           last_model;
  bit           cmd_we   [2];
  logic [A-1:0] cmd_addr [2];
  logic [W-1:0] cmd_data [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int id);
    if (id == 0) begin
      bus.we0 = cmd_we[0]; bus.addr0 = cmd_addr[0]; bus.wdata0 = cmd_data[0]; bus.req0 = 1'b1;
    end else begin
      bus.we1 = cmd_we[1]; bus.addr1 = cmd_addr[1]; bus.wdata1 = cmd_data[1]; bus.req1 = 1'b1;
    end
  endtask

  task automatic drop(input int id);
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic rand_cmd(input int id);
    cmd_we[id]   = 1'($urandom_range(0, 1));
    cmd_addr[id] = A'($urandom_range(0, 2**A - 1));
    cmd_data[id] = W'($urandom_range(0, 2**W - 1));
  endtask

  // Single requester access starting at a negedge with the arbiter idle.
  task automatic access1(input int id, input bit we, input logic [A-1:0] addr,
                         input logic [W-1:0] data);
    int cyc = 0; bit got = 0; int wen = 0;
    cmd_we[id] = we; cmd_addr[id] = addr; cmd_data[id] = data;
    drive(id);
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_write_en) begin
        wen++;
        chk("serve_addr", 32'(bus.mem_address), 32'(addr));
        chk("serve_wdata", 32'(bus.mem_data_in), 32'(data));
      end
      if ((id == 0) ? bus.ack0 : bus.ack1) got = 1;
    end
    chk("acc_ack_seen", 32'(got), 1);
    chk("acc_latency", cyc, 2);
    chk("acc_wen_cycles", wen, 32'(we));
    chk("acc_grant", 32'(bus.grant_id), 32'(id));
    chk("acc_other_ack", 32'((id == 0) ? bus.ack1 : bus.ack0), 0);
    if (!we) chk("acc_rdata", 32'(bus.rdata), 32'(ref_mem[addr]));
    else ref_mem[addr] = data;
    last_model = id[0];
    drop(id);
    @(negedge clk);
    chk("acc_ack_pulse", 32'(bus.ack0 | bus.ack1), 0);
    chk("acc_idle_busy", 32'(bus.busy), 0);
  endtask

  // Both requesters active; n acks collected. With regen, the served requester
  // presents a fresh random command; otherwise it drops its request.
  task automatic run_both(input int n, input bit regen);
    bit pend [2];
    int got_n = 0; int cyc; bit ok; bit exp_id; int exp_lat = 2;
    pend[0] = 1; pend[1] = 1;
    drive(0); drive(1);
    while (got_n < n) begin
      // Round-robin rule: a tie goes to the requester not granted last time.
      exp_id = (pend[0] && pend[1]) ? !last_model : pend[1];
      cyc = 0; ok = 0;
      while (!ok && cyc < 8) begin
        @(negedge clk);
        cyc++;
        if (bus.ack0 || bus.ack1) ok = 1;
      end
      chk("both_ack_seen", 32'(ok), 1);
      if (!ok) break;
      chk("both_latency", cyc, exp_lat);
      chk("both_grant", 32'(bus.grant_id), 32'(exp_id));
      chk("both_ack_owner", 32'(exp_id ? bus.ack1 : bus.ack0), 1);
      chk("both_ack_other", 32'(exp_id ? bus.ack0 : bus.ack1), 0);
      if (!cmd_we[exp_id]) begin
        exp_q.push_back(ref_mem[cmd_addr[exp_id]]);
        chk("both_rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
      end else begin
        ref_mem[cmd_addr[exp_id]] = cmd_data[exp_id];
      end
      last_model = exp_id;
      got_n++;
      exp_lat = 3;
      if (regen && got_n < n) begin
        rand_cmd(int'(exp_id)); drive(int'(exp_id));
      end else begin
        pend[exp_id] = 0; drop(int'(exp_id));
      end
    end
    drop(0); drop(1);
    @(negedge clk);
    chk("both_ack_pulse", 32'(bus.ack0 | bus.ack1), 0);
    @(negedge clk);
    chk("both_idle_busy", 32'(bus.busy), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 2**A; i++) begin
      logic [W-1:0] v;
      v = W'($urandom_range(0, 2**W - 1));
      core[i] = v;
      ref_mem[i] = v;
    end
    last_model = 1'b1;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ack", 32'({bus.ack1, bus.ack0}), 0);
      chk("idle_wen", 32'(bus.mem_write_en), 0);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_rdata", 32'(bus.rdata), 0);
      chk("idle_grant", 32'(bus.grant_id), 0);
    end

    // 2. write then read back on requester 0
    access1(0, 1'b1, 8'h10, 8'hA5);
    access1(0, 1'b0, 8'h10, 8'h00);

    // 3. simultaneous reads, requester 0 first after reset-free history
    access1(1, 1'b1, 8'h01, 8'h11);
    access1(1, 1'b1, 8'h02, 8'h22);
    cmd_we[0] = 0; cmd_addr[0] = 8'h01; cmd_data[0] = 8'h00;
    cmd_we[1] = 0; cmd_addr[1] = 8'h02; cmd_data[1] = 8'h00;
    run_both(2, 1'b0);

    // 4. both held with random commands: strict alternation
    rand_cmd(0); rand_cmd(1);
    run_both(10, 1'b1);

    // 5. reset in the middle of a write on requester 1
    cmd_we[1] = 1; cmd_addr[1] = 8'h20; cmd_data[1] = 8'h5A;
    drive(1);
    @(negedge clk);
    chk("rst_pre_wen", 32'(bus.mem_write_en), 1);
    rst = 1'b1;
    #1;
    chk("rst_wen", 32'(bus.mem_write_en), 0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_state", 32'(state), 0);
    drop(1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_commit", 32'(core[8'h20]), 32'(ref_mem[8'h20]));
    rst = 1'b0;
    last_model = 1'b1;
    @(negedge clk);

    // 6. command changes after grant are ignored, early drop still acks
    cmd_we[0] = 1; cmd_addr[0] = 8'h30; cmd_data[0] = 8'h77;
    drive(0);
    @(negedge clk);
    bus.addr0 = 8'h31; bus.wdata0 = 8'h99; bus.we0 = 1'b0; bus.req0 = 1'b0;
    #1;
    chk("lat_addr", 32'(bus.mem_address), 32'h30);
    chk("lat_wdata", 32'(bus.mem_data_in), 32'h77);
    chk("lat_wen", 32'(bus.mem_write_en), 1);
    @(negedge clk);
    chk("lat_ack", 32'(bus.ack0), 1);
    ref_mem[8'h30] = 8'h77;
    last_model = 1'b0;
    @(negedge clk);
    chk("lat_core30", 32'(core[8'h30]), 32'h77);
    chk("lat_core31", 32'(core[8'h31]), 32'(ref_mem[8'h31]));
    access1(0, 1'b0, 8'h30, 8'h00);

    // tie after requester 0 was last: requester 1 wins
    rand_cmd(0); rand_cmd(1);
    run_both(4, 1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
